// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes used by the control decoder and the
// execute stage, plus the execute-stage state encoding.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_SLL = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU control decoder (master) and the
// execute stage (slave).
interface alu_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         funct;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;

    modport master (
        output in_valid, funct, src_a, src_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, funct, src_a, src_b, shamt, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_core.sv
// Combinational add/sub/or datapath. For sll it passes b through, which is
// the zero-shift result; nonzero shifts are done iteratively by alu_exec.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = b;
        case (funct)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_OR:  y = a | b;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage: single-cycle add/sub/or, iterative
// one-bit-per-cycle shift-left, valid/ready on both sides.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus,
    output alu_state_e state_dbg
);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   core_y;
    logic               accept;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .funct (bus.funct),
        .a     (bus.src_a),
        .b     (bus.src_b),
        .y     (core_y)
    );

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Inputs are sampled only at the accept edge; out_valid/result hold until
    // out_ready. in_ready reflects out_ready combinationally in DONE so a
    // new request can be taken in the same edge the result is consumed.
    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
    assign state_dbg     = state_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && bus.out_ready)
                    state_d = IDLE;
                if (accept) begin
                    // result_q doubles as the shift accumulator; out_valid is
                    // low while it moves, so the consumer never sees it.
                    result_d = core_y;
                    if (bus.funct == ALU_SLL && bus.shamt != '0) begin
                        cnt_d   = bus.shamt;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                result_d = result_q << 1;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases, then randomized
// operations compared against a plain-arithmetic reference model.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int W = 32;

    logic       clk;
    logic       rst_n;
    alu_state_e state_dbg;

    alu_exec_if #(.WIDTH(W), .SHAMT_W(5)) io ();

    alu_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (io),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] f, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [4:0] sh);
        case (f)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLL: return b << sh;
            default: return a | b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] f, input logic [4:0] sh);
        return (f == ALU_SLL && sh != 0) ? 1 + int'(sh) : 1;
    endfunction

    task automatic pop_and_check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, io.result, e);
            check({tag, "_zero"}, {31'd0, io.zero}, {31'd0, (e == '0)});
        end
    endtask

    // ---------------- driver ----------------
    // One complete transaction: accept, measure latency, stall the output
    // for 'stall' cycles, then consume it.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh, input int stall);
        int   lat;
        logic saw_ready;
        logic stable;
        logic [W-1:0] held;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.funct    = f;
        io.src_a    = a;
        io.src_b    = b;
        io.shamt    = sh;
        check({tag, "_in_ready"}, {31'd0, io.in_ready}, 32'd1);
        @(posedge clk);
        exp_q.push_back(ref_result(f, a, b, sh));
        #1;
        io.in_valid = 1'b0;
        io.funct    = 2'($urandom_range(0, 3));
        io.src_a    = $urandom;
        io.src_b    = $urandom;
        io.shamt    = 5'($urandom_range(0, 31));
        lat = 0;
        saw_ready = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (io.out_valid) break;
            if (io.in_ready) saw_ready = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(ref_latency(f, sh)));
        check({tag, "_busy_ready"}, {31'd0, saw_ready}, 32'd0);
        held   = io.result;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!io.out_valid || io.in_ready || io.result !== held) stable = 1'b0;
        end
        check({tag, "_stall_stable"}, {31'd0, stable}, 32'd1);
        io.out_ready = 1'b1;
        #1;
        check({tag, "_done_ready"}, {31'd0, io.in_ready}, 32'd1);
        pop_and_check({tag, "_result"});
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {31'd0, io.out_valid}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]   f;
        logic [W-1:0] a, b;
        logic [4:0]   sh;

        io.in_valid  = 1'b0;
        io.funct     = ALU_ADD;
        io.src_a     = '0;
        io.src_b     = '0;
        io.shamt     = '0;
        io.out_ready = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("rst_result", io.result, 32'd0);
        check("rst_zero", {31'd0, io.zero}, 32'd1);
        check("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
        rst_n = 1'b1;

        run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0);
        run_op("sub_wrap", ALU_SUB, 32'd3, 32'd5, 5'd0, 0);
        run_op("sll_4", ALU_SLL, 32'h0, 32'h0000_0003, 5'd4, 0);
        run_op("sll_0", ALU_SLL, 32'h1234_5678, 32'hDEAD_BEEF, 5'd0, 1);
        run_op("sll_31", ALU_SLL, 32'h0, 32'h0000_0001, 5'd31, 2);

        // Back-pressure then back-to-back accept in the consuming edge
        @(negedge clk);
        io.in_valid = 1'b1;
        io.funct    = ALU_OR;
        io.src_a    = 32'hF0;
        io.src_b    = 32'h0F;
        @(posedge clk);
        exp_q.push_back(32'hFF);
        #1;
        io.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, io.out_valid}, 32'd1);
            check("bp_result", io.result, 32'hFF);
            check("bp_in_ready", {31'd0, io.in_ready}, 32'd0);
        end
        io.out_ready = 1'b1;
        io.in_valid  = 1'b1;
        io.funct     = ALU_ADD;
        io.src_a     = 32'd2;
        io.src_b     = 32'd2;
        #1;
        check("b2b_in_ready", {31'd0, io.in_ready}, 32'd1);
        pop_and_check("b2b_first");
        @(posedge clk);
        exp_q.push_back(32'd4);
        #1;
        io.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", {31'd0, io.out_valid}, 32'd1);
        pop_and_check("b2b_second");
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        @(negedge clk);
        check("b2b_idle", {31'd0, io.out_valid}, 32'd0);

        // Reset in the middle of a long shift
        io.in_valid = 1'b1;
        io.funct    = ALU_SLL;
        io.src_b    = 32'h0000_0005;
        io.shamt    = 5'd20;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("midrst_result", io.result, 32'd0);
        check("midrst_zero", {31'd0, io.zero}, 32'd1);
        check("midrst_in_ready", {31'd0, io.in_ready}, 32'd1);
        check("midrst_state", {30'd0, state_dbg}, {30'd0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_add", ALU_ADD, 32'd100, 32'd23, 5'd0, 0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            f  = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? -a : $urandom;
            sh = 5'($urandom_range(0, 31));
            if (f == ALU_SLL && $urandom_range(0, 3) == 0) sh = 5'd0;
            run_op("rand", f, a, b, sh, $urandom_range(0, 3));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
